// File: rtl/config_frame_writer.sv
// Purpose: groups strobed 32-bit config words into addressed frames and commits each to the frame registers.
// Latency: commit is registered on the edge that samples the last data word; frame_strobe is high for one cycle.
// Backpressure: none; every strobe is consumed or dropped on its own edge, so no stall is ever exerted upstream.
module config_frame_writer #(
    parameter int FRAME_WORDS = 4,
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_FRAMES  = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     strobe,
    input  logic [31:0]              data_in,
    input  logic                     finished,
    output logic                     frame_strobe,
    output logic [ADDR_WIDTH-1:0]    frame_addr,
    output logic [32*FRAME_WORDS-1:0] frame_data,
    output logic [15:0]              frames_written,
    output logic [7:0]               error_count,
    output logic                     busy,
    output logic                     done
);

    localparam int DW = 32 * FRAME_WORDS;
    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);
    localparam logic [7:0] HDR_MARKER = 8'hFA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DW-1:0]           buf_q, buf_d;
    logic [ADDR_WIDTH-1:0]   addr_pend_q, addr_pend_d;
    logic [ADDR_WIDTH-1:0]   frame_addr_q, frame_addr_d;
    logic [DW-1:0]           frame_data_q, frame_data_d;
    logic                    frame_strobe_q, frame_strobe_d;
    logic [15:0]             frames_written_q, frames_written_d;
    logic [7:0]              error_count_q, error_count_d;

    logic                    fw_inc;
    logic                    err_inc;
    logic [DW-1:0]           shifted;
    logic                    addr_ok;

    // Incoming word enters at the LSB end so word 0 ends up in the MSBs.
    assign shifted = {buf_q[DW-33:0], data_in};
    assign addr_ok = (32'(addr_pend_q) < 32'(NUM_FRAMES));

    // Next-state, frame assembly and commit decisions; finished beats a same-cycle strobe.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        buf_d          = buf_q;
        addr_pend_d    = addr_pend_q;
        frame_addr_d   = frame_addr_q;
        frame_data_d   = frame_data_q;
        frame_strobe_d = 1'b0;
        fw_inc         = 1'b0;
        err_inc        = 1'b0;
        case (state_q)
            IDLE: begin
                if (finished) begin
                    state_d = DONE;
                end else if (strobe) begin
                    if (data_in[31:24] == HDR_MARKER) begin
                        addr_pend_d = data_in[ADDR_WIDTH-1:0];
                        cnt_d       = '0;
                        state_d     = LOAD;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (finished) begin
                    // Partially loaded frame is abandoned and counted as dropped.
                    state_d = DONE;
                    err_inc = 1'b1;
                end else if (strobe) begin
                    buf_d = shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        if (addr_ok) begin
                            frame_data_d   = shifted;
                            frame_addr_d   = addr_pend_q;
                            frame_strobe_d = 1'b1;
                            fw_inc         = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        frames_written_d = frames_written_q;
        if (fw_inc && (frames_written_q != 16'hFFFF)) begin
            frames_written_d = frames_written_q + 16'd1;
        end
        error_count_d = error_count_q;
        if (err_inc && (error_count_q != 8'hFF)) begin
            error_count_d = error_count_q + 8'd1;
        end
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            buf_q            <= '0;
            addr_pend_q      <= '0;
            frame_addr_q     <= '0;
            frame_data_q     <= '0;
            frame_strobe_q   <= 1'b0;
            frames_written_q <= '0;
            error_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            buf_q            <= buf_d;
            addr_pend_q      <= addr_pend_d;
            frame_addr_q     <= frame_addr_d;
            frame_data_q     <= frame_data_d;
            frame_strobe_q   <= frame_strobe_d;
            frames_written_q <= frames_written_d;
            error_count_q    <= error_count_d;
        end
    end

    assign frame_strobe   = frame_strobe_q;
    assign frame_addr     = frame_addr_q;
    assign frame_data     = frame_data_q;
    assign frames_written = frames_written_q;
    assign error_count    = error_count_q;
    assign busy           = (state_q == LOAD);
    assign done           = (state_q == DONE);

endmodule

// File: tb/tb_config_frame_writer.sv
// Purpose: directed and random stimulus for config_frame_writer against a queue-based frame model.
// Latency: outputs are checked 1 time unit after each rising edge.
// Backpressure: not applicable; the design never stalls its input.
module tb_config_frame_writer;

    localparam int FW = 4;
    localparam int AW = 5;
    localparam int NF = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              strobe = 1'b0;
    logic [31:0]       data_in = '0;
    logic              finished = 1'b0;
    logic              frame_strobe;
    logic [AW-1:0]     frame_addr;
    logic [32*FW-1:0]  frame_data;
    logic [15:0]       frames_written;
    logic [7:0]        error_count;
    logic              busy;
    logic              done;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: a frame is a header followed by a list of FW words.
    logic          m_in_frame = 1'b0;
    logic          m_ended = 1'b0;
    int            m_pend = 0;
    logic [31:0]   m_q[$];
    logic          m_strobe = 1'b0;
    int            m_addr = 0;
    logic [127:0]  m_data = '0;
    int            m_fw = 0;
    int            m_err = 0;

    config_frame_writer #(.FRAME_WORDS(FW), .ADDR_WIDTH(AW), .NUM_FRAMES(NF)) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .data_in(data_in), .finished(finished),
        .frame_strobe(frame_strobe), .frame_addr(frame_addr), .frame_data(frame_data),
        .frames_written(frames_written), .error_count(error_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic s, input logic [31:0] d, input logic f);
        logic [127:0] v;
        m_strobe = 1'b0;
        if (r) begin
            m_in_frame = 0; m_ended = 0; m_pend = 0; m_q.delete();
            m_addr = 0; m_data = '0; m_fw = 0; m_err = 0;
        end else if (m_ended) begin
            // terminal: nothing changes
        end else if (f) begin
            if (m_in_frame && m_err < 255) m_err++;
            m_in_frame = 0;
            m_ended = 1;
        end else if (s) begin
            if (!m_in_frame) begin
                if (d[31:24] == 8'hFA) begin
                    m_in_frame = 1;
                    m_pend = int'(d[AW-1:0]);
                    m_q.delete();
                end else if (m_err < 255) begin
                    m_err++;
                end
            end else begin
                m_q.push_back(d);
                if (m_q.size() == FW) begin
                    m_in_frame = 0;
                    if (m_pend < NF) begin
                        v = '0;
                        foreach (m_q[i]) v = {v[95:0], m_q[i]};
                        m_data = v;
                        m_addr = m_pend;
                        m_strobe = 1'b1;
                        if (m_fw < 65535) m_fw++;
                    end else if (m_err < 255) begin
                        m_err++;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [31:0] d, input logic f);
        reset = r; strobe = s; data_in = d; finished = f;
        @(posedge clk);
        #1;
        model(r, s, d, f);
        strobe = 1'b0;
        chk("frame_strobe", 128'(frame_strobe), 128'(m_strobe));
        chk("frame_addr", 128'(frame_addr), 128'(m_addr));
        chk("frame_data", frame_data, m_data);
        chk("frames_written", 128'(frames_written), 128'(m_fw));
        chk("error_count", 128'(error_count), 128'(m_err));
        chk("busy", 128'(busy), 128'(m_in_frame));
        chk("done", 128'(done), 128'(m_ended));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, finished);
    endtask

    initial begin
        logic [31:0] w;
        logic        r;
        logic        s;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 1, 32'hFA000001, 0);
        step(0, 0, 0, 0);

        // Basic frame to address 3, consecutive strobes
        step(0, 1, 32'hFA000003, 0);
        step(0, 1, 32'h11111111, 0);
        step(0, 1, 32'h22222222, 0);
        step(0, 1, 32'h33333333, 0);
        step(0, 1, 32'h44444444, 0);
        chk("plan1_pulse", 128'(frame_strobe), 128'd1);
        chk("plan1_data", frame_data, 128'h11111111_22222222_33333333_44444444);
        chk("plan1_addr", 128'(frame_addr), 128'd3);
        step(0, 0, 0, 0);
        chk("plan1_pulse_low", 128'(frame_strobe), 128'd0);

        // Bad marker: header and the following words all count as errors
        step(1, 0, 0, 0);
        step(0, 1, 32'hAB000001, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, {8'(i), 24'h123456}, 0);
        chk("plan2_err", 128'(error_count), 128'd5);

        // Out-of-range address keeps the prior committed frame
        step(1, 0, 0, 0);
        step(0, 1, 32'hFA000002, 0);
        for (int i = 0; i < FW; i++) step(0, 1, 32'hC0DE0000 + 32'(i), 0);
        step(0, 1, 32'hFA000017, 0);
        for (int i = 0; i < FW; i++) step(0, 1, 32'hBAD00000 + 32'(i), 0);
        chk("plan3_err", 128'(error_count), 128'd1);
        chk("plan3_addr", 128'(frame_addr), 128'd2);

        // Two frames at addresses 0 and 19; back-to-back then spaced by 5 idles
        step(1, 0, 0, 0);
        step(0, 1, 32'hFA000000, 0);
        for (int i = 0; i < FW; i++) step(0, 1, $urandom, 0);
        step(0, 1, 32'hFA000013, 0);
        for (int i = 0; i < FW; i++) begin
            idle(5);
            step(0, 1, $urandom, 0);
        end
        chk("plan5_fw", 128'(frames_written), 128'd2);
        chk("plan5_addr", 128'(frame_addr), 128'd19);

        // Reset mid-frame then a fresh frame to address 7
        step(0, 1, 32'hFA000005, 0);
        step(0, 1, 32'h01010101, 0);
        step(0, 1, 32'h02020202, 0);
        step(1, 0, 0, 0);
        step(0, 1, 32'hFA000007, 0);
        for (int i = 0; i < FW; i++) step(0, 1, $urandom, 0);
        chk("plan6_fw", 128'(frames_written), 128'd1);
        chk("plan6_addr", 128'(frame_addr), 128'd7);

        // Random traffic: mixed headers, gaps and occasional resets
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) != 0);
            w = $urandom;
            if ($urandom_range(0, 2) == 0) w[31:24] = 8'hFA;
            step(r, s, w, 0);
        end

        // Error counter saturation
        step(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 1, 32'h00000000 + 32'(i), 0);
        chk("err_sat", 128'(error_count), 128'hFF);

        // Abort mid-frame: finished on the third data strobe
        step(1, 0, 0, 0);
        step(0, 1, 32'hFA000004, 0);
        step(0, 1, 32'hAAAA0001, 0);
        step(0, 1, 32'hAAAA0002, 0);
        step(0, 1, 32'hAAAA0003, 1);
        chk("abort_err", 128'(error_count), 128'd1);
        chk("abort_done", 128'(done), 128'd1);
        step(0, 1, 32'hFA000001, 1);
        for (int i = 0; i < FW + 2; i++) step(0, 1, $urandom, 1);
        chk("done_sticky", 128'(done), 128'd1);

        // Reset leaves DONE
        step(1, 0, 0, 0);
        finished = 1'b0;
        step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
